vga_rect_gen: RTL
=================

VGA_RECT_GEN -- requirements
Module: vga_rect_gen

Interface
REQ-001 SHALL have parameter H_VIS, default 640, meaning visible pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, meaning horizontal front porch, sync and back porch in pixels.
REQ-003 SHALL have parameter V_VIS, default 480, meaning visible lines per frame.
REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, meaning vertical front porch, sync and back porch in lines.
REQ-005 SHALL have parameter COLOR_W, default 4, meaning bits per colour channel.
REQ-006 SHALL have parameter CLK_DIV, default 2, meaning CLOCK_50 cycles per pixel (legal 1..16).
REQ-007 SHALL have parameter SYNC_POL, default 0, meaning active level of VGA_HS/VGA_VS.
REQ-008 SHALL have ports: CLOCK_50 input 1 system clock; reset input 1, synchronous active-high.
REQ-009 SHALL have ports: rect_x0, rect_x1 input 11 rectangle column bounds (inclusive); rect_y0, rect_y1 input 11 row bounds (inclusive).
REQ-010 SHALL have ports: rect_color input 3*COLOR_W {R,G,B}; VGA_HS, VGA_VS output 1 sync; VGA_R, VGA_G, VGA_B output COLOR_W each.
REQ-011 SHALL have ports: frame_start output 1 one-CLOCK_50 pulse; pix_x, pix_y output 11 current counter values.

Function
REQ-012 SHALL assert an internal pixel enable (pe) for one CLOCK_50 cycle in every CLK_DIV cycles; CLK_DIV=1 gives pe always high.
REQ-013 SHALL advance pix_x on pe, 0..H_TOTAL-1, then wrap to 0, where H_TOTAL=H_VIS+H_FP+H_SYNC+H_BP (800 default).
REQ-014 SHALL advance pix_y on pe only when pix_x wraps, 0..V_TOTAL-1, then wrap to 0, where V_TOTAL=525 default.
REQ-015 SHALL produce sync active when H_VIS+H_FP <= pix_x < H_VIS+H_FP+H_SYNC (656..751), and likewise for vertical (490..491).
REQ-016 SHALL drive VGA_HS/VGA_VS at SYNC_POL while active and at ~SYNC_POL otherwise.
REQ-017 SHALL register sync and colour outputs together, giving one-pe latency from counter value to pins; sync and RGB always align.
REQ-018 SHALL latch rect_* and rect_color into shadow registers on the pe where pix_x=0 and pix_y=0, and set a shadow-valid flag at the same time; mid-frame input changes SHALL have no effect until the next frame.
REQ-019 SHALL drive rect_color on RGB when shadow-valid and x0<=pix_x<=x1 and y0<=pix_y<=y1; x0>x1 or y0>y1 SHALL yield an empty rectangle.
REQ-020 SHALL drive RGB=0 outside the rectangle and during all blanking (pix_x>=H_VIS or pix_y>=V_VIS), including where the rectangle bounds extend into blanking.
REQ-021 SHALL pulse frame_start for the single CLOCK_50 cycle on which the shadow latch occurs.
REQ-022 SHALL use 11-bit unsigned compares only; no arithmetic wraps beyond H_TOTAL/V_TOTAL.

Reset
REQ-023 SHALL, while reset is high at a CLOCK_50 edge, clear the divider, pix_x, pix_y, shadow-valid, shadow registers, RGB and frame_start, and drive sync outputs at ~SYNC_POL.
REQ-024 SHALL, on reset asserted mid-frame, abort the frame; the first pe after release SHALL be pix_x=0, pix_y=0 and SHALL latch the shadows.

Configuration
REQ-025 SHALL, with VGA_BORDER_EN defined, drive all-ones RGB when pix_x is 0 or H_VIS-1, or pix_y is 0 or V_VIS-1, with priority over the rectangle.
REQ-026 SHALL, without VGA_BORDER_EN, contain no border logic; RGB follows REQ-019/020 only.

Verification
REQ-027 SHALL cover: reset, then 2*800*525 CLOCK_50 cycles at defaults -> exactly one frame_start; HS low 96 pixels/line starting at pix_x 656; VS low lines 490-491.
REQ-028 SHALL cover: rect 200..299 x 200..299, colour 12'hF00 -> R=F exactly at pixels (200..299, 200..299), one pe after the counter; 0 elsewhere.
REQ-029 SHALL cover: rect_x1 changed to 400 at pix_y=250 -> current frame unchanged; next frame uses 400.
REQ-030 SHALL cover: x0=300, x1=200 -> no coloured pixel all frame; rect 600..700 -> colour stops at pix_x 639.
REQ-031 SHALL cover: reset pulsed at pix_x=100, pix_y=300 -> outputs idle during reset; next pe gives (0,0) and a frame_start pulse.
REQ-032 SHALL cover: VGA_BORDER_EN defined, CLK_DIV=1, SYNC_POL=1 -> white at (0,y), (639,y), (x,0), (x,479); syncs high-active; one pixel per clock.

Source files
------------

// File: rtl/vga_rect_gen.sv
// vga_rect_gen: VGA timing generator drawing one frame-latched rectangle.
// Define VGA_BORDER_EN to add an all-ones border around the visible area.
module vga_rect_gen #(
    parameter int H_VIS    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_VIS    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int COLOR_W  = 4,
    parameter int CLK_DIV  = 2,
    parameter int SYNC_POL = 0
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic [10:0]            rect_x0,
    input  logic [10:0]            rect_x1,
    input  logic [10:0]            rect_y0,
    input  logic [10:0]            rect_y1,
    input  logic [3*COLOR_W-1:0]   rect_color,
    output logic                   VGA_HS,
    output logic                   VGA_VS,
    output logic [COLOR_W-1:0]     VGA_R,
    output logic [COLOR_W-1:0]     VGA_G,
    output logic [COLOR_W-1:0]     VGA_B,
    output logic                   frame_start,
    output logic [10:0]            pix_x,
    output logic [10:0]            pix_y
);
    localparam int CW3 = 3 * COLOR_W;
    localparam logic [3:0]  DIV_M1 = 4'(CLK_DIV - 1);
    localparam logic [10:0] HT_M1  = 11'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] VT_M1  = 11'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [10:0] HS_ON  = 11'(H_VIS + H_FP);
    localparam logic [10:0] HS_OFF = 11'(H_VIS + H_FP + H_SYNC);
    localparam logic [10:0] VS_ON  = 11'(V_VIS + V_FP);
    localparam logic [10:0] VS_OFF = 11'(V_VIS + V_FP + V_SYNC);
    localparam logic [10:0] HV     = 11'(H_VIS);
    localparam logic [10:0] VV     = 11'(V_VIS);
    localparam logic        POL    = 1'(SYNC_POL);
`ifdef VGA_BORDER_EN
    localparam logic [10:0] HV_M1  = 11'(H_VIS - 1);
    localparam logic [10:0] VV_M1  = 11'(V_VIS - 1);
`endif

    logic [3:0]     div_q, div_d;
    logic [10:0]    x_q, x_d, y_q, y_d;
    logic [10:0]    sx0_q, sx0_d, sx1_q, sx1_d, sy0_q, sy0_d, sy1_q, sy1_d;
    logic [CW3-1:0] sc_q, sc_d, rgb_q, rgb_d, pix_rgb;
    logic           sval_q, sval_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
    logic           pe, sh_load, x_wrap, vis, in_rect, hs_act, vs_act;

    always_comb begin
        pe      = div_q == DIV_M1;
        sh_load = pe && x_q == 11'd0 && y_q == 11'd0;
        x_wrap  = x_q == HT_M1;
        div_d   = pe ? 4'd0 : div_q + 4'd1;
        x_d     = pe ? (x_wrap ? 11'd0 : x_q + 11'd1) : x_q;
        y_d     = (pe && x_wrap) ? (y_q == VT_M1 ? 11'd0 : y_q + 11'd1) : y_q;
        sx0_d   = sh_load ? rect_x0 : sx0_q;
        sx1_d   = sh_load ? rect_x1 : sx1_q;
        sy0_d   = sh_load ? rect_y0 : sy0_q;
        sy1_d   = sh_load ? rect_y1 : sy1_q;
        sc_d    = sh_load ? rect_color : sc_q;
        sval_d  = sval_q | sh_load;
        // Pixel (0,0) already uses the values being latched on this pe.
        in_rect = sval_d && sx0_d <= x_q && x_q <= sx1_d && sy0_d <= y_q && y_q <= sy1_d;
        vis     = x_q < HV && y_q < VV;
`ifdef VGA_BORDER_EN
        pix_rgb = !vis ? '0 :
                  (x_q == 11'd0 || x_q == HV_M1 || y_q == 11'd0 || y_q == VV_M1) ? '1 :
                  in_rect ? sc_d : '0;
`else
        pix_rgb = (vis && in_rect) ? sc_d : '0;
`endif
        hs_act  = x_q >= HS_ON && x_q < HS_OFF;
        vs_act  = y_q >= VS_ON && y_q < VS_OFF;
        hs_d    = pe ? (hs_act ? POL : ~POL) : hs_q;
        vs_d    = pe ? (vs_act ? POL : ~POL) : vs_q;
        rgb_d   = pe ? pix_rgb : rgb_q;
        fs_d    = sh_load;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            div_q  <= 4'd0;
            x_q    <= 11'd0;
            y_q    <= 11'd0;
            sx0_q  <= 11'd0;
            sx1_q  <= 11'd0;
            sy0_q  <= 11'd0;
            sy1_q  <= 11'd0;
            sc_q   <= '0;
            sval_q <= 1'b0;
            hs_q   <= ~POL;
            vs_q   <= ~POL;
            rgb_q  <= '0;
            fs_q   <= 1'b0;
        end else begin
            div_q  <= div_d;
            x_q    <= x_d;
            y_q    <= y_d;
            sx0_q  <= sx0_d;
            sx1_q  <= sx1_d;
            sy0_q  <= sy0_d;
            sy1_q  <= sy1_d;
            sc_q   <= sc_d;
            sval_q <= sval_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            rgb_q  <= rgb_d;
            fs_q   <= fs_d;
        end
    end

    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_R       = rgb_q[CW3-1 -: COLOR_W];
    assign VGA_G       = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign VGA_B       = rgb_q[COLOR_W-1:0];
    assign frame_start = fs_q;
    assign pix_x       = x_q;
    assign pix_y       = y_q;
endmodule
